// File: rtl/axis_frame_stream_transmitter.sv
// rtl/axis_frame_stream_transmitter.sv - AXI4-Stream frame transmitter with input FIFO, SOF/EOF framing
// Pixel words are buffered in a FIFO ahead of a single output register; beat index drives tuser/tlast.
module axis_frame_stream_transmitter #(
   parameter int DATA_WIDTH         = 32,
   parameter int FIFO_DEPTH         = 16,
   parameter int ALMOST_FULL_MARGIN = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   pixels_per_frame,
   input  logic                          frame_start,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic                          frame_done,
   output logic                          overflow,
   output logic                          excess_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state, state_next;
   logic [31:0]           ppf_q;
   logic [31:0]           in_cnt;
   logic [31:0]           out_cnt;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         level;
   logic                  out_valid, out_last, out_user;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  done_q, overflow_q, excess_q;

   logic                  streaming, fifo_full, fifo_empty, cnt_ok;
   logic                  handshake, load, wr_en, excess_hit, ovf_hit;
   logic                  frame_end, start_ok, zero_start, done_next;
   logic [31:0]           ld_idx;

   always_comb begin
      streaming  = (state == STREAM);
      fifo_full  = (level == LW'(FIFO_DEPTH));
      fifo_empty = (level == '0);
      cnt_ok     = (in_cnt < ppf_q);
      handshake  = out_valid && m_axis_tready;
      load       = !fifo_empty && (!out_valid || m_axis_tready);
      wr_en      = streaming && in_valid && cnt_ok && !fifo_full;
      excess_hit = streaming && in_valid && !cnt_ok;
      ovf_hit    = streaming && in_valid && cnt_ok && fifo_full;
      // A load while the register is busy implies its beat is leaving now, so the new index is one past it.
      ld_idx     = out_cnt + {31'b0, out_valid};
      frame_end  = streaming && handshake && out_last;
      start_ok   = (state == IDLE) && frame_start && (pixels_per_frame != 32'd0);
      zero_start = (state == IDLE) && frame_start && (pixels_per_frame == 32'd0);
      done_next  = frame_end || zero_start;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok)  state_next = STREAM;
         STREAM:  if (frame_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ppf_q   <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            ppf_q   <= pixels_per_frame;
            in_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (wr_en)     in_cnt  <= in_cnt + 32'd1;
            if (handshake) out_cnt <= out_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (load)  rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, load})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_user  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= mem[rd_ptr];
         out_user  <= (ld_idx == 32'd0);
         out_last  <= (ld_idx == ppf_q - 32'd1);
      end else if (handshake) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_user  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         excess_q   <= 1'b0;
      end else begin
         done_q <= done_next;
         if (ovf_hit)    overflow_q <= 1'b1;
         if (excess_hit) excess_q   <= 1'b1;
      end
   end

   assign in_ready      = streaming && cnt_ok && (level < LW'(FIFO_DEPTH - ALMOST_FULL_MARGIN));
   assign m_axis_tdata  = out_data;
   assign m_axis_tvalid = out_valid;
   assign m_axis_tlast  = out_last;
   assign m_axis_tuser  = out_user;
   assign frame_done    = done_q;
   assign overflow      = overflow_q;
   assign excess_err    = excess_q;
   assign fifo_level    = level;

endmodule

// File: tb/tb_axis_frame_stream_transmitter.sv
// tb/tb_axis_frame_stream_transmitter.sv - self-checking bench for axis_frame_stream_transmitter
module tb_axis_frame_stream_transmitter;

   localparam int DW = 32;
   localparam logic [31:0] BASE = 32'hA500_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   pixels_per_frame = '0;
   logic          frame_start = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          frame_done;
   logic          overflow;
   logic          excess_err;
   logic [4:0]    fifo_level;

   always #5 clk = ~clk;

   axis_frame_stream_transmitter #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(16), .ALMOST_FULL_MARGIN(2)
   ) dut (
      .clk(clk), .rst(rst), .pixels_per_frame(pixels_per_frame), .frame_start(frame_start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .frame_done(frame_done),
      .overflow(overflow), .excess_err(excess_err), .fifo_level(fifo_level)
   );

   typedef struct {
      int ppf;
      int nwords;
      int mode;      // 0: tready=1, 1: tready 1,0,0,1, 2: tready=0 while feeding then 1
      bit respect;   // producer honours in_ready
      int exp_beats;
      bit exp_done;
      bit exp_ov;
      bit exp_ex;
   } vec_t;

   vec_t vecs[7];

   int checks = 0;
   int errors = 0;
   int done_cnt;
   logic [31:0] bd[$];
   bit bu[$];
   bit bl[$];
   bit prev_stall = 1'b0;
   logic [31:0] p_data;
   logic p_last, p_user;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
         if (prev_stall)
            chk("stall hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                {1'b1, p_last, p_user, p_data});
         if (m_axis_tvalid && m_axis_tready) begin
            bd.push_back(m_axis_tdata);
            bu.push_back(m_axis_tuser);
            bl.push_back(m_axis_tlast);
         end
         if (frame_done) done_cnt++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         p_data = m_axis_tdata;
         p_last = m_axis_tlast;
         p_user = m_axis_tuser;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      bd.delete();
      bu.delete();
      bl.delete();
      done_cnt = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      frame_start = 1'b0;
      in_valid = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   function automatic bit ready_pat(input int mode, input int cyc, input bit active);
      case (mode)
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         2:       return !active;
         default: return 1'b1;
      endcase
   endfunction

   task automatic check_beats(input string tag, input int exp_n, input bit exp_done);
      int bad_d, bad_u, bad_l;
      bad_d = 0; bad_u = 0; bad_l = 0;
      chk({tag, " beat count"}, bd.size(), exp_n);
      for (int i = 0; i < bd.size(); i++) begin
         if (bd[i] !== BASE + 32'(i)) bad_d++;
         if (bu[i] != (i == 0)) bad_u++;
         if (bl[i] != (exp_done && i == exp_n - 1)) bad_l++;
      end
      chk({tag, " data order errors"}, bad_d, 0);
      chk({tag, " tuser errors"}, bad_u, 0);
      chk({tag, " tlast errors"}, bad_l, 0);
   endtask

   task automatic run_vec(input vec_t v, input bit with_rst, input string tag);
      int sent, cyc, budget;
      if (with_rst) do_reset();
      clear_log();
      pixels_per_frame = 32'(v.ppf);
      frame_start = 1'b1;
      m_axis_tready = ready_pat(v.mode, 0, 1'b1);
      tick();
      frame_start = 1'b0;
      sent = 0;
      cyc = 0;
      while (sent < v.nwords && cyc < 2000) begin
         m_axis_tready = ready_pat(v.mode, cyc, 1'b1);
         in_valid = v.respect ? in_ready : 1'b1;
         in_data = BASE + 32'(sent);
         if (in_valid) sent++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      budget = v.exp_done ? 1000 : 60;
      for (int k = 0; k < budget && done_cnt == 0; k++) begin
         m_axis_tready = ready_pat(v.mode, cyc, 1'b0);
         tick();
         cyc++;
      end
      for (int k = 0; k < 3; k++) tick();
      check_beats(tag, v.exp_beats, v.exp_done);
      chk({tag, " frame_done pulses"}, done_cnt, v.exp_done ? 1 : 0);
      chk({tag, " overflow"}, overflow, v.exp_ov);
      chk({tag, " excess_err"}, excess_err, v.exp_ex);
      if (v.exp_done) chk({tag, " idle in_ready"}, in_ready, 1'b0);
   endtask

   initial begin
      bit saw13, saw14;
      int guard;

      vecs[0] = '{256, 256, 0, 1'b0, 256, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{ 64,  64, 1, 1'b1,  64, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{ 64,  20, 2, 1'b0,  17, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{  4,   6, 0, 1'b0,   4, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{  8,   8, 1, 1'b1,   8, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{  0,   0, 0, 1'b0,   0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{  1,   1, 0, 1'b0,   1, 1'b1, 1'b0, 1'b0};
      clear_log();

      do_reset();
      chk("reset tvalid", m_axis_tvalid, 1'b0);
      chk("reset tlast/tuser", {m_axis_tlast, m_axis_tuser}, 2'b00);
      chk("reset in_ready", in_ready, 1'b0);
      chk("reset level", fifo_level, 5'd0);
      chk("reset flags", {overflow, excess_err, frame_done}, 3'b000);

      // Latency: word written at one edge appears on tvalid after the next.
      pixels_per_frame = 32'd4;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      in_valid = 1'b1;
      in_data = BASE;
      tick();
      in_valid = 1'b0;
      chk("latency tvalid early", m_axis_tvalid, 1'b0);
      chk("latency level", fifo_level, 5'd1);
      tick();
      chk("latency tvalid", m_axis_tvalid, 1'b1);
      chk("latency beat", {m_axis_tuser, m_axis_tdata}, {1'b1, BASE});
      chk("latency level drained", fifo_level, 5'd0);

      // Almost-full threshold and overflow stickiness with a stalled sink.
      do_reset();
      pixels_per_frame = 32'd64;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      saw13 = 1'b0;
      saw14 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (fifo_level == 5'd13 && !saw13) begin
            saw13 = 1'b1;
            chk("in_ready at level 13", in_ready, 1'b1);
         end
         if (fifo_level == 5'd14 && !saw14) begin
            saw14 = 1'b1;
            chk("in_ready at level 14", in_ready, 1'b0);
         end
         in_valid = 1'b1;
         in_data = BASE + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("level 14 reached", saw14, 1'b1);
      chk("full level", fifo_level, 5'd16);
      chk("overflow set", overflow, 1'b1);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("overflow sticky", overflow, 1'b1);

      foreach (vecs[i]) run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));

      // Reset mid-frame discards the partial frame, then a fresh frame starts cleanly.
      do_reset();
      clear_log();
      pixels_per_frame = 32'd256;
      frame_start = 1'b1;
      m_axis_tready = 1'b1;
      tick();
      frame_start = 1'b0;
      guard = 0;
      while (bd.size() < 100 && guard < 400) begin
         in_valid = 1'b1;
         in_data = BASE + 32'(guard);
         tick();
         guard++;
      end
      check_beats("pre-reset", 100, 1'b0);
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("midreset tvalid", m_axis_tvalid, 1'b0);
      chk("midreset level", fifo_level, 5'd0);
      chk("midreset flags", {overflow, excess_err, frame_done, in_ready}, 4'b0000);
      rst = 1'b0;
      run_vec(vecs[4], 1'b0, "post-reset");

      // frame_start during STREAM is ignored; frame_done follows the tlast handshake by one cycle.
      do_reset();
      clear_log();
      pixels_per_frame = 32'd4;
      frame_start = 1'b1;
      m_axis_tready = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = BASE + 32'(i);
         frame_start = (i == 2);
         pixels_per_frame = (i == 2) ? 32'd8 : 32'd4;
         tick();
      end
      in_valid = 1'b0;
      frame_start = 1'b0;
      guard = 0;
      while (!(m_axis_tvalid && m_axis_tlast) && guard < 50) begin
         tick();
         guard++;
      end
      chk("tlast seen", m_axis_tvalid && m_axis_tlast, 1'b1);
      tick();
      chk("frame_done after tlast", frame_done, 1'b1);
      tick();
      chk("frame_done one cycle", frame_done, 1'b0);
      chk("idle after frame", in_ready, 1'b0);
      check_beats("mid-start", 4, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
